// File: rtl/arm_regfile_mp_if.sv
// Register file port bundle: read selects/data, write, reserve and clear.
interface arm_regfile_mp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_sel;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_sel;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_sel;
  logic                     clr_req;
  logic                     clr_busy;

  modport master (
    output rd_sel, wr_en, wr_sel, wr_data,
    output rsv_en, rsv_sel, clr_req,
    input  rd_data, busy, clr_busy
  );

  modport slave (
    input  rd_sel, wr_en, wr_sel, wr_data,
    input  rsv_en, rsv_sel, clr_req,
    output rd_data, busy, clr_busy
  );
endinterface

// File: rtl/arm_regfile_mp.sv
// Multi-read-port register file with XZR, pending scoreboard and clear sweep.
// Define RF_BYPASS_EN to forward same-cycle writes to matching reads.
module arm_regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 31
) (
  input  logic            clk,
  input  logic            rst,
  arm_regfile_mp_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              clr_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr_acc;
  logic              rsv_acc;

  assign wr_acc  = bus.wr_en && state == IDLE
                   && bus.wr_sel != ZR;
  assign rsv_acc = bus.rsv_en && state == IDLE
                   && bus.rsv_sel != ZR;
  assign bus.clr_busy = clr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      clr_q   <= 1'b0;
      pending <= '0;
      for (int j = 0; j < DEPTH; j++)
        mem[j] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_acc) begin
            mem[bus.wr_sel]     <= bus.wr_data;
            pending[bus.wr_sel] <= 1'b0;
          end
          // reserve is applied last so it wins over a same-register write
          if (rsv_acc)
            pending[bus.rsv_sel] <= 1'b1;
          if (bus.clr_req) begin
            state <= CLEAR;
            clr_q <= 1'b1;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          mem[cnt]     <= '0;
          pending[cnt] <= 1'b0;
          cnt          <= cnt + ADDR_W'(1);
          if (cnt == LAST) begin
            state <= IDLE;
            clr_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] sel;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign sel = bus.rd_sel[i*ADDR_W +: ADDR_W];

    always_comb begin
      data = (sel == ZR) ? '0 : mem[sel];
      bsy  = pending[sel];
`ifdef RF_BYPASS_EN
      if (wr_acc && bus.wr_sel == sel) begin
        data = bus.wr_data;
        bsy  = rsv_acc && bus.rsv_sel == sel;
      end
`endif
    end

    assign bus.rd_data[i*DATA_W +: DATA_W] = data;
    assign bus.busy[i] = bsy;
  end
endmodule

// File: tb/tb_arm_regfile_mp.sv
// Bench for arm_regfile_mp: array model with per-cycle compare plus directed literals.
module tb_arm_regfile_mp;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEP = 32;
  localparam int ZR = 31;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  arm_regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  arm_regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(ZR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else
      n_pass++;
  endtask

  // Architectural model: register array, pending array, sweep cycles left
  logic [63:0] m_reg [DEP];
  bit          m_pend [DEP];
  int          m_left = 0;

  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEP; k++) begin
        m_reg[k]  <= '0;
        m_pend[k] <= 1'b0;
      end
      m_left <= 0;
    end else if (m_left == 0) begin
      if (bus.wr_en && int'(bus.wr_sel) != ZR) begin
        m_reg[bus.wr_sel]  <= bus.wr_data;
        m_pend[bus.wr_sel] <= 1'b0;
      end
      if (bus.rsv_en && int'(bus.rsv_sel) != ZR)
        m_pend[bus.rsv_sel] <= 1'b1;
      if (bus.clr_req)
        m_left <= DEP;
    end else begin
      m_reg[DEP - m_left]  <= '0;
      m_pend[DEP - m_left] <= 1'b0;
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NR; i++) begin
        int s;
        logic [63:0] ed;
        logic eb;
        s  = int'(bus.rd_sel[i*AW +: AW]);
        ed = (s == ZR) ? 64'd0 : m_reg[s];
        eb = m_pend[s];
`ifdef RF_BYPASS_EN
        if (m_left == 0 && bus.wr_en && int'(bus.wr_sel) != ZR
            && int'(bus.wr_sel) == s) begin
          ed = bus.wr_data;
          eb = bus.rsv_en && int'(bus.rsv_sel) == s;
        end
`endif
        check($sformatf("model_rd%0d", i), bus.rd_data[i*DW +: DW], ed);
        check($sformatf("model_busy%0d", i), 64'(bus.busy[i]), 64'(eb));
      end
      check("model_clr_busy", 64'(bus.clr_busy), 64'(m_left != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.wr_en   = 1'b0;
    bus.rsv_en  = 1'b0;
    bus.clr_req = 1'b0;
  endtask

  task automatic set_rd(input int a, input int b);
    bus.rd_sel = {AW'(b), AW'(a)};
  endtask

  task automatic wr(input int sel, input logic [63:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = AW'(sel);
    bus.wr_data = d;
  endtask

  initial begin
    int n;
    logic [63:0] exp_byp;
    bus.rd_sel  = '0;
    bus.wr_sel  = '0;
    bus.wr_data = '0;
    bus.rsv_sel = '0;
    idle_in();

    tick(); tick();
    rst = 1'b1;
    chk_en = 1'b1;

    // reset after prior write to X1
    wr(1, 64'h5);
    tick(); idle_in(); set_rd(1, 1); #1;
    check("pre_reset_x1", bus.rd_data[63:0], 64'h5);
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1; #1;
    check("reset_rd0", bus.rd_data[63:0], 64'd0);
    check("reset_rd1", bus.rd_data[127:64], 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_clr_busy", 64'(bus.clr_busy), 64'd0);

    // write/read, dual port same select, XZR
    wr(3, 64'hDEADBEEF00000001);
    tick(); idle_in(); set_rd(3, 3); #1;
    check("x3_port0", bus.rd_data[63:0], 64'hDEADBEEF00000001);
    check("x3_port1", bus.rd_data[127:64], 64'hDEADBEEF00000001);
    wr(31, 64'hFF);
    tick(); idle_in(); set_rd(31, 3); #1;
    check("xzr_read", bus.rd_data[63:0], 64'd0);
    check("xzr_busy", 64'(bus.busy[0]), 64'd0);

    // scoreboard
    bus.rsv_en = 1'b1; bus.rsv_sel = AW'(4);
    tick(); idle_in(); set_rd(4, 3); #1;
    check("rsv_busy", 64'(bus.busy[0]), 64'd1);
    wr(4, 64'h7);
    tick(); idle_in(); #1;
    check("wr_clears_busy", 64'(bus.busy[0]), 64'd0);
    check("x4_data", bus.rd_data[63:0], 64'h7);
    wr(4, 64'h7);
    bus.rsv_en = 1'b1; bus.rsv_sel = AW'(4);
    tick(); idle_in(); #1;
    check("rsv_wins_busy", 64'(bus.busy[0]), 64'd1);
    check("rsv_wins_data", bus.rd_data[63:0], 64'h7);

    // same-cycle write and read of X2
    set_rd(2, 4);
    wr(2, 64'h11); #1;
`ifdef RF_BYPASS_EN
    exp_byp = 64'h11;
`else
    exp_byp = 64'h0;
`endif
    check("bypass_x2", bus.rd_data[63:0], exp_byp);
    tick(); idle_in(); #1;
    check("x2_next", bus.rd_data[63:0], 64'h11);

    // fill and sweep
    for (int r = 0; r < 31; r++) begin
      wr(r, 64'(r + 1));
      tick();
    end
    idle_in(); set_rd(10, 30); #1;
    check("fill_x10", bus.rd_data[63:0], 64'd11);
    check("fill_x30", bus.rd_data[127:64], 64'd31);
    bus.clr_req = 1'b1;
    tick(); idle_in();
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (!bus.clr_busy) break;
      n++;
      if (k == 3) begin
        set_rd(20, 0); #1;
        check("unswept_x20", bus.rd_data[63:0], 64'd21);
      end
      if (k == 20) begin
        wr(5, 64'h55);
        bus.rsv_en = 1'b1; bus.rsv_sel = AW'(6);
        bus.clr_req = 1'b1;
      end
      if (k == 21) idle_in();
      tick();
    end
    idle_in();
    check("sweep_cycles", 64'(n), 64'd32);
    for (int r = 0; r < DEP; r += 2) begin
      set_rd(r, r + 1); #1;
      check($sformatf("swept_x%0d", r), bus.rd_data[63:0], 64'd0);
      check($sformatf("swept_x%0d", r + 1), bus.rd_data[127:64], 64'd0);
      check($sformatf("swept_busy%0d", r), 64'(bus.busy), 64'd0);
    end
    check("idle_after_sweep", 64'(bus.clr_busy), 64'd0);

    // reset mid-sweep
    wr(7, 64'h77);
    tick(); idle_in();
    bus.clr_req = 1'b1;
    tick(); idle_in();
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; set_rd(7, 20); #1;
    check("midsweep_clr_busy", 64'(bus.clr_busy), 64'd0);
    check("midsweep_x7", bus.rd_data[63:0], 64'd0);
    check("midsweep_x20", bus.rd_data[127:64], 64'd0);
    wr(7, 64'h99);
    tick(); idle_in(); #1;
    check("post_reset_wr", bus.rd_data[63:0], 64'h99);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/arm_regfile_mp.md
ARM_REGFILE_MP -- requirements
Module: arm_regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, select width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, legal 1..4, number of read ports.
REQ-004 SHALL have parameter ZERO_REG, default 31, index of hardwired-zero register (XZR).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-007 SHALL have port rd_sel  input  NUM_RD*ADDR_W  packed read selects, port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data  output  NUM_RD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W].
REQ-009 SHALL have port busy  output  NUM_RD  per-read-port pending flag of selected register.
REQ-010 SHALL have port wr_en  input  1  write enable.
REQ-011 SHALL have port wr_sel  input  ADDR_W  write select.
REQ-012 SHALL have port wr_data  input  DATA_W  write data.
REQ-013 SHALL have port rsv_en  input  1  scoreboard reserve enable.
REQ-014 SHALL have port rsv_sel  input  ADDR_W  register to mark pending.
REQ-015 SHALL have port clr_req  input  1  start clear sweep (level sampled in IDLE).
REQ-016 SHALL have port clr_busy  output  1  high while sweep runs.

Function
REQ-017 SHALL read combinationally: rd_data[i] = reg[rd_sel[i]]; all ports independent, same select allowed on several ports.
REQ-018 SHALL write wr_data to reg[wr_sel] on edge when wr_en=1, FSM in IDLE, wr_sel != ZERO_REG.
REQ-019 SHALL always return 0 for reads of ZERO_REG; writes to it discarded.
REQ-020 SHALL keep pending[DEPTH]: rsv_en sets pending[rsv_sel] next edge; accepted write clears pending[wr_sel] next edge.
REQ-021 SHALL let reserve win when rsv_en and wr_en target same register same cycle (pending stays 1, data still written).
REQ-022 SHALL never set pending[ZERO_REG]; busy[i] = pending[rd_sel[i]] combinational.
REQ-023 SHALL implement FSM IDLE/CLEAR: IDLE->CLEAR when clr_req=1; CLEAR walks counter 0..DEPTH-1, one register zeroed and its pending cleared per cycle; CLEAR->IDLE after index DEPTH-1 written.
REQ-024 SHALL take exactly DEPTH cycles in CLEAR; clr_busy=1 for exactly those cycles, 0 otherwise.
REQ-025 SHALL ignore wr_en, rsv_en and clr_req while in CLEAR; reads remain valid (unswept registers return old data).
REQ-026 SHALL accept wr_en/rsv_en in the same cycle clr_req is sampled in IDLE (last IDLE cycle), sweep then overwrites.

Reset
REQ-027 SHALL, on rising edge with rst=0, zero all registers, clear all pending bits, FSM to IDLE, counter to 0.
REQ-028 SHALL give rd_data=0, busy=0, clr_busy=0 the cycle after reset regardless of selects.
REQ-029 SHALL abort an in-progress sweep on reset, with reset taking priority over every other input.

Configuration
REQ-030 SHALL support macro RF_BYPASS_EN: when defined, a read whose rd_sel equals wr_sel with an accepted write (REQ-018) returns wr_data that same cycle, and busy for that port is 0 unless rsv_en targets it.
REQ-031 SHALL, without RF_BYPASS_EN, return stored (pre-write) data and stored pending state on such reads; new value visible next cycle.

Verification
REQ-032 SHALL test reset: rst=0 two edges with prior writes to X1=0x5 -> rd_data all 0, busy=0, clr_busy=0.
REQ-033 SHALL test write/read: wr X3=0xDEADBEEF00000001, next cycle rd_sel0=3, rd_sel1=3 -> both 0xDEADBEEF00000001; wr X31=0xFF -> rd X31=0.
REQ-034 SHALL test scoreboard: rsv X4, then rd_sel0=4 -> busy[0]=1; wr X4=0x7 -> busy[0]=0 next cycle; same-cycle rsv+wr X4 -> busy stays 1, data 0x7.
REQ-035 SHALL test bypass: wr X2=0x11 with rd_sel0=2 same cycle -> 0x11 with RF_BYPASS_EN, old value (0) without.
REQ-036 SHALL test sweep: fill X0..X30 with index+1, pulse clr_req -> clr_busy high 32 cycles, wr X5 during sweep ignored, all registers 0 after.
REQ-037 SHALL test reset mid-sweep at cycle 10 -> clr_busy 0 next cycle, all registers 0, new writes accepted immediately.
